// File: rtl/reset_sequencer.sv
// reset_sequencer: lock-qualified, staggered multi-channel reset release.
// Optional soft reset in RUN when RSTSEQ_SWRST_EN is defined.
module reset_sequencer #(
  parameter int NCH     = 4,
  parameter int STRETCH = 100,
  parameter int GAP     = 16
) (
  input  logic           CLK,
  input  logic           RST_X_I,
  input  logic           LOCKED_I,
  input  logic           SWRST_REQ_I,
  output logic [NCH-1:0] RST_X_O,
  output logic           READY_O,
  output logic           LOSS_O,
  output logic [1:0]     STATE_O
);

  localparam int MAXC = (STRETCH > GAP) ? STRETCH : GAP;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0]  STR_TC = CW'(STRETCH - 1);
  localparam logic [CW-1:0]  GAP_TC = CW'(GAP - 1);
  localparam logic [NCH-1:0] CH0    = NCH'(1);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [NCH-1:0]  rst_q;
  logic            ready_q;
  logic            loss_q;
  logic [1:0]      sync_q;
  logic            locked_s;
  logic            swrst_hit;
  logic [NCH-1:0]  rel_nxt;

  assign locked_s = sync_q[1];

  // Channels release strictly in order: thermometer grows by one bit.
  assign rel_nxt = (rst_q << 1) | CH0;

`ifdef RSTSEQ_SWRST_EN
  assign swrst_hit = SWRST_REQ_I;
`else
  logic unused_swrst;
  assign unused_swrst = SWRST_REQ_I;
  assign swrst_hit    = 1'b0;
`endif

  // Bring the asynchronous lock indication into the CLK domain.
  always_ff @(posedge CLK or negedge RST_X_I) begin
    if (!RST_X_I) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], LOCKED_I};
    end
  end

  // Sequencer: stretch after lock, stagger releases, drop all on loss.
  always_ff @(posedge CLK or negedge RST_X_I) begin
    if (!RST_X_I) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      rst_q   <= '0;
      ready_q <= 1'b0;
      loss_q  <= 1'b0;
    end else begin
      unique case (state_q)
        HOLD: begin
          if (!locked_s) begin
            cnt_q <= '0;
            rst_q <= '0;
          end else if (cnt_q == STR_TC) begin
            cnt_q <= '0;
            rst_q <= CH0;
            if (NCH == 1) begin
              ready_q <= 1'b1;
              state_q <= RUN;
            end else begin
              state_q <= RELEASE;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RELEASE: begin
          if (!locked_s) begin
            cnt_q   <= '0;
            rst_q   <= '0;
            ready_q <= 1'b0;
            loss_q  <= 1'b1;
            state_q <= HOLD;
          end else if (cnt_q == GAP_TC) begin
            cnt_q <= '0;
            rst_q <= rel_nxt;
            if (rel_nxt[NCH-1]) begin
              ready_q <= 1'b1;
              state_q <= RUN;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RUN: begin
          if (!locked_s) begin
            cnt_q   <= '0;
            rst_q   <= '0;
            ready_q <= 1'b0;
            loss_q  <= 1'b1;
            state_q <= HOLD;
          end else if (swrst_hit) begin
            cnt_q   <= '0;
            rst_q   <= '0;
            ready_q <= 1'b0;
            state_q <= HOLD;
          end
        end
        default: begin
          cnt_q   <= '0;
          rst_q   <= '0;
          ready_q <= 1'b0;
          state_q <= HOLD;
        end
      endcase
    end
  end

  assign RST_X_O = rst_q;
  assign READY_O = ready_q;
  assign LOSS_O  = loss_q;
  assign STATE_O = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: scoreboard bench for reset_sequencer.
// Expected output changes are queued and matched against observed changes.
module tb_reset_sequencer;

  localparam int ST = 100;
  localparam int GP = 16;

  logic       CLK = 1'b0;
  logic       RST_X_I;
  logic       LOCKED_I;
  logic       SWRST_REQ_I;
  logic [3:0] RST_X_O;
  logic       READY_O;
  logic       LOSS_O;
  logic [1:0] STATE_O;

  logic       rst1_n;
  logic [0:0] r1_rst;
  logic       r1_rdy;
  logic       r1_loss;
  logic [1:0] r1_st;

  always #5 CLK = ~CLK;

  reset_sequencer dut (
    .CLK(CLK), .RST_X_I(RST_X_I), .LOCKED_I(LOCKED_I),
    .SWRST_REQ_I(SWRST_REQ_I), .RST_X_O(RST_X_O),
    .READY_O(READY_O), .LOSS_O(LOSS_O), .STATE_O(STATE_O)
  );

  reset_sequencer #(.NCH(1), .STRETCH(1), .GAP(1)) dut1 (
    .CLK(CLK), .RST_X_I(rst1_n), .LOCKED_I(LOCKED_I),
    .SWRST_REQ_I(SWRST_REQ_I), .RST_X_O(r1_rst),
    .READY_O(r1_rdy), .LOSS_O(r1_loss), .STATE_O(r1_st)
  );

  typedef struct {
    int         edge_n;
    logic [3:0] rst;
    logic       rdy;
    logic [1:0] st;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        obs_q[$];
  int         ecnt;
  logic [3:0] prev;
  int         errors = 0;
  int         checks = 0;

  function automatic ev_t mk(input int n, input logic [3:0] r,
                             input logic y, input logic [1:0] s);
    ev_t e;
    e.edge_n = n;
    e.rst    = r;
    e.rdy    = y;
    e.st     = s;
    return e;
  endfunction

  // Full release schedule with ch0 at base+STRETCH.
  task automatic push_seq(input int base);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(mk(base + ST + k * GP, 4'((1 << (k + 1)) - 1),
                         k == 3, (k == 3) ? 2'd2 : 2'd1));
    end
  endtask

  // Step n edges, capturing every change of RST_X_O.
  task automatic watch(input int n);
    repeat (n) begin
      @(posedge CLK);
      ecnt++;
      #1;
      if (RST_X_O !== prev) begin
        obs_q.push_back(mk(ecnt, RST_X_O, READY_O, STATE_O));
        prev = RST_X_O;
      end
    end
  endtask

  task automatic restart(input logic lk);
    RST_X_I  = 1'b0;
    LOCKED_I = lk;
    repeat (2) @(posedge CLK);
    #1;
    RST_X_I = 1'b1;
    ecnt    = 0;
    prev    = 4'h0;
  endtask

  task automatic test_reset;
    RST_X_I     = 1'b1;
    LOCKED_I    = 1'b1;
    SWRST_REQ_I = 1'b0;
    rst1_n      = 1'b1;
    #2;
    RST_X_I = 1'b0;
    rst1_n  = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (RST_X_O !== 4'h0) begin
      errors++;
      $display("FAIL reset_rst: got %h required 0", RST_X_O);
    end
    checks++;
    if (READY_O !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b required 0", READY_O);
    end
    checks++;
    if (LOSS_O !== 1'b0) begin
      errors++;
      $display("FAIL reset_loss: got %b required 0", LOSS_O);
    end
    checks++;
    if (STATE_O !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d required 0", STATE_O);
    end
  endtask

  task automatic test_power_up;
    ev_t e, o;
    RST_X_I = 1'b1;
    ecnt    = 0;
    prev    = 4'h0;
    push_seq(2);
    watch(160);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL power_up: no change, required rst=%h at edge %0d",
                 e.rst, e.edge_n);
      end else begin
        o = obs_q.pop_front();
        if (o.edge_n !== e.edge_n || o.rst !== e.rst ||
            o.rdy !== e.rdy || o.st !== e.st) begin
          errors++;
          $display("FAIL power_up: got e%0d rst=%h rdy=%b st=%0d, required e%0d rst=%h rdy=%b st=%0d",
                   o.edge_n, o.rst, o.rdy, o.st, e.edge_n, e.rst, e.rdy, e.st);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL power_up_extra: got %0d extra changes required 0",
               obs_q.size());
      obs_q.delete();
    end
    checks++;
    if (LOSS_O !== 1'b0) begin
      errors++;
      $display("FAIL power_up_loss: got %b required 0", LOSS_O);
    end
  endtask

  task automatic test_lock_loss;
    ev_t e, o;
    int  e0;
    e0 = ecnt;
    exp_q.push_back(mk(e0 + 3, 4'h0, 1'b0, 2'd0));
    push_seq(e0 + 5);
    LOCKED_I = 1'b0;
    watch(3);
    LOCKED_I = 1'b1;
    checks++;
    if (LOSS_O !== 1'b1) begin
      errors++;
      $display("FAIL lock_loss_flag: got %b required 1", LOSS_O);
    end
    watch(160);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL lock_loss: no change, required rst=%h at edge %0d",
                 e.rst, e.edge_n);
      end else begin
        o = obs_q.pop_front();
        if (o.edge_n !== e.edge_n || o.rst !== e.rst ||
            o.rdy !== e.rdy || o.st !== e.st) begin
          errors++;
          $display("FAIL lock_loss: got e%0d rst=%h rdy=%b st=%0d, required e%0d rst=%h rdy=%b st=%0d",
                   o.edge_n, o.rst, o.rdy, o.st, e.edge_n, e.rst, e.rdy, e.st);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL lock_loss_extra: got %0d extra changes required 0",
               obs_q.size());
      obs_q.delete();
    end
    checks++;
    if (LOSS_O !== 1'b1) begin
      errors++;
      $display("FAIL lock_loss_sticky: got %b required 1", LOSS_O);
    end
  endtask

  task automatic test_lock_late;
    ev_t e, o;
    restart(1'b0);
    checks++;
    if (LOSS_O !== 1'b0) begin
      errors++;
      $display("FAIL late_loss_clr: got %b required 0", LOSS_O);
    end
    watch(500);
    LOCKED_I = 1'b1;
    push_seq(502);
    watch(160);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL lock_late: no change, required rst=%h at edge %0d",
                 e.rst, e.edge_n);
      end else begin
        o = obs_q.pop_front();
        if (o.edge_n !== e.edge_n || o.rst !== e.rst ||
            o.rdy !== e.rdy || o.st !== e.st) begin
          errors++;
          $display("FAIL lock_late: got e%0d rst=%h rdy=%b st=%0d, required e%0d rst=%h rdy=%b st=%0d",
                   o.edge_n, o.rst, o.rdy, o.st, e.edge_n, e.rst, e.rdy, e.st);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL lock_late_extra: got %0d extra changes required 0",
               obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_async_reset;
    ev_t e, o;
    restart(1'b1);
    exp_q.push_back(mk(2 + ST, 4'h1, 1'b0, 2'd1));
    watch(110);
    #2;
    RST_X_I = 1'b0;
    #1;
    checks++;
    if (RST_X_O !== 4'h0 || READY_O !== 1'b0 || STATE_O !== 2'd0) begin
      errors++;
      $display("FAIL async_rst: got rst=%h rdy=%b st=%0d required 0 0 0",
               RST_X_O, READY_O, STATE_O);
    end
    checks++;
    if (LOSS_O !== 1'b0) begin
      errors++;
      $display("FAIL async_loss: got %b required 0", LOSS_O);
    end
    #1;
    RST_X_I = 1'b1;
    if (obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.edge_n !== e.edge_n || o.rst !== e.rst ||
          o.rdy !== e.rdy || o.st !== e.st) begin
        errors++;
        $display("FAIL async_pre: got e%0d rst=%h rdy=%b st=%0d, required e%0d rst=%h rdy=%b st=%0d",
                 o.edge_n, o.rst, o.rdy, o.st, e.edge_n, e.rst, e.rdy, e.st);
      end
    end
    ecnt = 0;
    prev = 4'h0;
    push_seq(2);
    watch(160);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL async_seq: no change, required rst=%h at edge %0d",
                 e.rst, e.edge_n);
      end else begin
        o = obs_q.pop_front();
        if (o.edge_n !== e.edge_n || o.rst !== e.rst ||
            o.rdy !== e.rdy || o.st !== e.st) begin
          errors++;
          $display("FAIL async_seq: got e%0d rst=%h rdy=%b st=%0d, required e%0d rst=%h rdy=%b st=%0d",
                   o.edge_n, o.rst, o.rdy, o.st, e.edge_n, e.rst, e.rdy, e.st);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL async_extra: got %0d extra changes required 0",
               obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_swrst;
    ev_t e, o;
    int  e0;
    e0 = ecnt;
`ifdef RSTSEQ_SWRST_EN
    exp_q.push_back(mk(e0 + 1, 4'h0, 1'b0, 2'd0));
    push_seq(e0 + 1);
    SWRST_REQ_I = 1'b1;
    watch(1);
    SWRST_REQ_I = 1'b0;
    watch(103);
    SWRST_REQ_I = 1'b1;
    watch(1);
    SWRST_REQ_I = 1'b0;
    watch(60);
`else
    SWRST_REQ_I = 1'b1;
    watch(1);
    SWRST_REQ_I = 1'b0;
    watch(30);
`endif
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL swrst: no change, required rst=%h at edge %0d",
                 e.rst, e.edge_n);
      end else begin
        o = obs_q.pop_front();
        if (o.edge_n !== e.edge_n || o.rst !== e.rst ||
            o.rdy !== e.rdy || o.st !== e.st) begin
          errors++;
          $display("FAIL swrst: got e%0d rst=%h rdy=%b st=%0d, required e%0d rst=%h rdy=%b st=%0d",
                   o.edge_n, o.rst, o.rdy, o.st, e.edge_n, e.rst, e.rdy, e.st);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL swrst_extra: got %0d extra changes required 0",
               obs_q.size());
      obs_q.delete();
    end
    checks++;
    if (LOSS_O !== 1'b0) begin
      errors++;
      $display("FAIL swrst_loss: got %b required 0", LOSS_O);
    end
  endtask

  task automatic test_nch1;
    ev_t  e, o;
    int   n1;
    logic p1;
    n1     = 0;
    p1     = 1'b0;
    rst1_n = 1'b1;
    exp_q.push_back(mk(3, 4'h1, 1'b1, 2'd2));
    repeat (8) begin
      @(posedge CLK);
      n1++;
      #1;
      if (r1_rst[0] !== p1) begin
        obs_q.push_back(mk(n1, {3'b000, r1_rst}, r1_rdy, r1_st));
        p1 = r1_rst[0];
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL nch1: no change, required rst=%h at edge %0d",
                 e.rst, e.edge_n);
      end else begin
        o = obs_q.pop_front();
        if (o.edge_n !== e.edge_n || o.rst !== e.rst ||
            o.rdy !== e.rdy || o.st !== e.st) begin
          errors++;
          $display("FAIL nch1: got e%0d rst=%h rdy=%b st=%0d, required e%0d rst=%h rdy=%b st=%0d",
                   o.edge_n, o.rst, o.rdy, o.st, e.edge_n, e.rst, e.rdy, e.st);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL nch1_extra: got %0d extra changes required 0",
               obs_q.size());
      obs_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_lock_loss();
    test_lock_late();
    test_async_reset();
    test_swrst();
    test_nch1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
